// File: rtl/mlp_ctrl.sv
// Control FSM for the MLP inference engine: weight initialisation, input load,
// per-layer multiply-accumulate over ping-pong activation banks, result hand-off.
// Drives SRAM strobes/addresses and datapath controls only; carries no data.
module mlp_ctrl #(
  parameter int unsigned Layers = 8,
  parameter int unsigned Dim    = 16,
  parameter int unsigned WAddrW = $clog2(Layers*Dim*Dim),
  parameter int unsigned XAddrW = $clog2(2*Dim),
  parameter int unsigned CfgW   = $clog2(Layers+1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_valid_i,
  output logic              init_ready_o,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [CfgW-1:0]   cfg_layers_i,
  input  logic              in_valid_i,
  input  logic              abort_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              result_bank_o,
  output logic              busy_o,
  output logic              w_ren_o,
  output logic              w_wen_o,
  output logic [WAddrW-1:0] w_addr_o,
  output logic              x_ren_o,
  output logic              x_wen_o,
  output logic              x_sel_o,
  output logic [XAddrW-1:0] x_addr_o,
  output logic              acc_clr_o,
  output logic              act_en_o
);

  localparam int unsigned DimW  = $clog2(Dim);
  localparam int unsigned LayW  = (Layers > 1) ? $clog2(Layers) : 1;
  localparam int unsigned Beats = Layers * Dim * Dim;

  localparam logic [WAddrW-1:0] KLast = WAddrW'(Beats - 1);
  localparam logic [DimW-1:0]   ILast = DimW'(Dim - 1);
  localparam logic [CfgW-1:0]   LMax  = CfgW'(Layers);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INITW,
    S_LOADX,
    S_ACC,
    S_WB,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [WAddrW-1:0] k_q;
  logic [LayW-1:0]   l_q;
  logic [DimW-1:0]   j_q;
  logic [DimW-1:0]   i_q;
  logic [CfgW-1:0]   lrun_q;

  logic [CfgW-1:0]   lrun_d;
  logic              last_layer;
  logic [31:0]       acc_waddr;

  // Runtime layer count: out-of-range requests (0 or above capacity) run every stored layer
  always_comb begin
    lrun_d = cfg_layers_i;
    if (cfg_layers_i == '0 || cfg_layers_i > LMax) begin
      lrun_d = LMax;
    end
  end

  assign last_layer = (CfgW'(l_q) == (lrun_q - CfgW'(1)));

  // State and counter sequencing; abort from any active state returns to Idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      l_q     <= '0;
      j_q     <= '0;
      i_q     <= '0;
      lrun_q  <= '0;
    end else if (abort_i && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      l_q     <= '0;
      j_q     <= '0;
      i_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (init_valid_i) begin
            // beat 0 is written from Idle, so InitW resumes at beat 1
            state_q <= S_INITW;
            k_q     <= WAddrW'(1);
          end else if (start_valid_i) begin
            state_q <= S_LOADX;
            lrun_q  <= lrun_d;
            i_q     <= '0;
          end
        end
        S_INITW: begin
          if (init_valid_i) begin
            if (k_q == KLast) begin
              k_q     <= '0;
              state_q <= S_IDLE;
            end else begin
              k_q <= k_q + WAddrW'(1);
            end
          end
        end
        S_LOADX: begin
          if (in_valid_i) begin
            if (i_q == ILast) begin
              i_q     <= '0;
              j_q     <= '0;
              l_q     <= '0;
              state_q <= S_ACC;
            end else begin
              i_q <= i_q + DimW'(1);
            end
          end
        end
        S_ACC: begin
          if (i_q == ILast) begin
            i_q     <= '0;
            state_q <= S_WB;
          end else begin
            i_q <= i_q + DimW'(1);
          end
        end
        S_WB: begin
          if (j_q != ILast) begin
            j_q     <= j_q + DimW'(1);
            state_q <= S_ACC;
          end else if (!last_layer) begin
            j_q     <= '0;
            l_q     <= l_q + LayW'(1);
            state_q <= S_ACC;
          end else begin
            j_q     <= '0;
            l_q     <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Flat weight index of the current product: layer, then neuron row, then input column
  assign acc_waddr = 32'(l_q) * Dim * Dim + 32'(j_q) * Dim + 32'(i_q);

  // Output decode from the current state and counters
  always_comb begin
    init_ready_o   = 1'b0;
    start_ready_o  = 1'b0;
    result_valid_o = 1'b0;
    result_bank_o  = 1'b0;
    busy_o         = 1'b1;
    w_ren_o        = 1'b0;
    w_wen_o        = 1'b0;
    w_addr_o       = '0;
    x_ren_o        = 1'b0;
    x_wen_o        = 1'b0;
    x_sel_o        = 1'b0;
    x_addr_o       = '0;
    acc_clr_o      = 1'b0;
    act_en_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o        = 1'b0;
        init_ready_o  = 1'b1;
        start_ready_o = !init_valid_i;
        w_wen_o       = init_valid_i;
      end
      S_INITW: begin
        init_ready_o = 1'b1;
        w_wen_o      = init_valid_i;
        w_addr_o     = k_q;
      end
      S_LOADX: begin
        x_wen_o  = in_valid_i;
        x_addr_o = {1'b0, i_q};
      end
      S_ACC: begin
        w_ren_o   = 1'b1;
        x_ren_o   = 1'b1;
        w_addr_o  = WAddrW'(acc_waddr);
        x_addr_o  = {l_q[0], i_q};
        acc_clr_o = (i_q == '0);
      end
      S_WB: begin
        // result goes to the bank opposite the one this layer reads
        x_wen_o  = 1'b1;
        x_sel_o  = 1'b1;
        x_addr_o = {~l_q[0], j_q};
        act_en_o = !last_layer;
      end
      S_DONE: begin
        result_valid_o = 1'b1;
        result_bank_o  = lrun_q[0];
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mlp_ctrl.sv
// Self-checking bench for mlp_ctrl: each cycle the full output set is compared
// against an expectation built from nested layer/neuron/input loops.
module tb_mlp_ctrl;

  localparam int D  = 16;
  localparam int NL = 8;
  localparam int NB = NL * D * D;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        init_valid_i;
  logic        init_ready_o;
  logic        start_valid_i;
  logic        start_ready_o;
  logic [3:0]  cfg_layers_i;
  logic        in_valid_i;
  logic        abort_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic        result_bank_o;
  logic        busy_o;
  logic        w_ren_o;
  logic        w_wen_o;
  logic [10:0] w_addr_o;
  logic        x_ren_o;
  logic        x_wen_o;
  logic        x_sel_o;
  logic [4:0]  x_addr_o;
  logic        acc_clr_o;
  logic        act_en_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wen_cnt  = 0;

  mlp_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .init_valid_i   (init_valid_i),
    .init_ready_o   (init_ready_o),
    .start_valid_i  (start_valid_i),
    .start_ready_o  (start_ready_o),
    .cfg_layers_i   (cfg_layers_i),
    .in_valid_i     (in_valid_i),
    .abort_i        (abort_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_bank_o  (result_bank_o),
    .busy_o         (busy_o),
    .w_ren_o        (w_ren_o),
    .w_wen_o        (w_wen_o),
    .w_addr_o       (w_addr_o),
    .x_ren_o        (x_ren_o),
    .x_wen_o        (x_wen_o),
    .x_sel_o        (x_sel_o),
    .x_addr_o       (x_addr_o),
    .acc_clr_o      (acc_clr_o),
    .act_en_o       (act_en_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle counter and weight-write pulse counter sampled on the active edge
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (w_wen_o === 1'b1) wen_cnt <= wen_cnt + 1;
  end

  // All outputs packed into one word for single-comparison-per-cycle checking
  function automatic logic [31:0] pk(input logic busy, ir, sr, rv, rb, wr, ww,
                                     input int wa, input logic xr, xw, xs,
                                     input int xa, input logic ac, ae);
    return {4'b0, busy, ir, sr, rv, rb, wr, ww, 11'(wa), xr, xw, xs, 5'(xa), ac, ae};
  endfunction

  logic [31:0] obs;
  assign obs = pk(busy_o, init_ready_o, start_ready_o, result_valid_o, result_bank_o,
                  w_ren_o, w_wen_o, int'(w_addr_o), x_ren_o, x_wen_o, x_sel_o,
                  int'(x_addr_o), acc_clr_o, act_en_o);

  function automatic int lrun(input int cfg);
    return (cfg == 0 || cfg > NL) ? NL : cfg;
  endfunction

  function automatic logic [31:0] e_idle(input logic iv);
    return pk(0, 1, !iv, 0, 0, 0, iv, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [31:0] e_init(input int k, input logic v);
    return pk(1, 1, 0, 0, 0, 0, v, k, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [31:0] e_load(input int i, input logic v);
    return pk(1, 0, 0, 0, 0, 0, 0, 0, 0, v, 0, i, 0, 0);
  endfunction
  function automatic logic [31:0] e_acc(input int l, input int j, input int i);
    return pk(1, 0, 0, 0, 0, 1, 0, l*D*D + j*D + i, 1, 0, 0, (l % 2)*D + i, i == 0, 0);
  endfunction
  function automatic logic [31:0] e_wb(input int l, input int j, input int nl);
    return pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ((l + 1) % 2)*D + j, 0, l != nl - 1);
  endfunction
  function automatic logic [31:0] e_done(input int nl);
    return pk(1, 0, 0, 1, logic'(nl % 2), 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Count one comparison and report it if the values differ
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1 time unit later
  task automatic step(input string tag, input logic [31:0] exp);
    #1 check_eq(tag, obs, exp);
    @(negedge clk_i);
  endtask

  // Full weight load; toggle=1 alternates valid 1,0, otherwise random gaps
  task automatic do_init(input bit toggle, input bit with_start, input int abort_k);
    int  k  = 1;
    int  c0;
    bit  v;
    bit  tg = 1'b0;
    c0 = wen_cnt;
    init_valid_i  = 1'b1;
    start_valid_i = with_start;
    step("init_idle", e_idle(1'b1));
    start_valid_i = 1'b0;
    while (k < NB) begin
      v  = toggle ? tg : 1'($urandom_range(0, 1));
      tg = ~tg;
      init_valid_i = v;
      if (abort_k != 0 && k == abort_k) begin
        abort_i = 1'b1;
        step("init_abort", e_init(k, v));
        abort_i = 1'b0;
        init_valid_i = 1'b0;
        step("init_abort_idle", e_idle(1'b0));
        return;
      end
      step("initw", e_init(k, v));
      if (v) k++;
    end
    init_valid_i = 1'b0;
    step("init_end_idle", e_idle(1'b0));
    check_eq("init_pulses", 32'(wen_cnt - c0), 32'(NB));
  endtask

  // One inference request; abort_l >= 0 aborts at a random product of that layer
  task automatic infer(input int cfg, input bit rnd_in, input int delay,
                       input int abort_l, input bit idle_abort, input bit addr_chk);
    int nl;
    int i;
    int aj;
    int ai;
    int c_start;
    bit v;
    nl = lrun(cfg);
    aj = $urandom_range(0, D - 1);
    ai = $urandom_range(0, D - 1);
    start_valid_i = 1'b1;
    cfg_layers_i  = 4'(cfg);
    abort_i       = idle_abort;
    #1 c_start = cyc;
    step("start_idle", e_idle(1'b0));
    start_valid_i = 1'b0;
    abort_i       = 1'b0;
    cfg_layers_i  = 4'($urandom_range(0, 15));
    i = 0;
    while (i < D) begin
      v = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_i = v;
      step("loadx", e_load(i, v));
      if (v) i++;
    end
    in_valid_i = 1'b0;
    for (int l = 0; l < nl; l++) begin
      for (int j = 0; j < D; j++) begin
        for (int ii = 0; ii < D; ii++) begin
          if (l == abort_l && j == aj && ii == ai) begin
            abort_i = 1'b1;
            step("acc_abort", e_acc(l, j, ii));
            abort_i = 1'b0;
            step("abort_idle", e_idle(1'b0));
            return;
          end
          if (addr_chk && l == 0 && j == 3 && ii == 5) begin
            #1 check_eq("w_addr_j3i5", 32'(w_addr_o), 32'd53);
            check_eq("x_addr_j3i5", 32'(x_addr_o), 32'd5);
          end
          step("acc", e_acc(l, j, ii));
        end
        step("wb", e_wb(l, j, nl));
      end
    end
    if (!rnd_in) begin
      #1 check_eq("done_latency", result_valid_o ? 32'(cyc - c_start) : 32'd0,
                  32'(D + nl*D*(D + 1) + 1));
    end
    for (int d = 0; d < delay; d++) begin
      result_ready_i = 1'b0;
      start_valid_i  = 1'($urandom_range(0, 1));
      step("done_hold", e_done(nl));
    end
    start_valid_i  = 1'b0;
    result_ready_i = 1'b1;
    step("done_ack", e_done(nl));
    result_ready_i = 1'b0;
    step("post_done_idle", e_idle(1'b0));
  endtask

  // Synchronous reset part-way through an input load
  task automatic reset_in_loadx(input int beats);
    start_valid_i = 1'b1;
    cfg_layers_i  = 4'd2;
    step("rst_start", e_idle(1'b0));
    start_valid_i = 1'b0;
    in_valid_i    = 1'b1;
    for (int i = 0; i < beats; i++) step("rst_loadx", e_load(i, 1'b1));
    rst_i = 1'b1;
    step("rst_cycle", e_load(beats, 1'b1));
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    step("rst_idle", e_idle(1'b0));
  endtask

  initial begin
    int cfg;
    int ab;
    rst_i          = 1'b1;
    init_valid_i   = 1'b0;
    start_valid_i  = 1'b0;
    cfg_layers_i   = 4'd0;
    in_valid_i     = 1'b0;
    abort_i        = 1'b0;
    result_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    step("reset", e_idle(1'b0));
    rst_i = 1'b0;
    step("idle", e_idle(1'b0));

    do_init(1'b1, 1'b1, 0);
    infer(2, 1'b0, 0, -1, 1'b1, 1'b0);
    infer(1, 1'b0, 0, -1, 1'b0, 1'b1);
    infer(2, 1'b0, 10, -1, 1'b0, 1'b0);
    infer(8, 1'b0, 0, 3, 1'b0, 1'b0);
    infer(0, 1'b0, 2, -1, 1'b0, 1'b0);
    reset_in_loadx(5);

    do_init(1'b0, 1'b0, $urandom_range(1, NB - 1));
    do_init(1'b0, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      cfg = $urandom_range(0, 15);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lrun(cfg) - 1) : -1;
      infer(cfg, 1'b1, $urandom_range(0, 5), ab, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
